mas_prog_loader: RTL and testbench
==================================

// Module: mas_prog_loader
// PURPOSE
//   Boot/program sequencer for the MAS16bA core. Receives a byte stream over a valid/ready link and
//   assembles 16-bit instruction words. Writes the words into instruction memory at consecutive
//   addresses while holding the core in program mode (pg=1). It then pulses the core reset and
//   releases the core into run mode (pg=0). This replaces hand-driven pg/rstz/pg_instr sequencing.
// PARAMETERS
//   ADDR_W      16    instruction memory address width
//   BASE_ADDR   0     address of the first loaded word
//   TIMEOUT     1024  max idle cycles between bytes mid-load before error abort
//   RST_CYCLES  2     cycles core_rst is held after a successful load (>=1)
// PORTS
//   clk        in   1       clock, all logic on rising edge
//   rstz       in   1       synchronous, active-high reset
//   start      in   1       begin a load session (sampled in IDLE or RUN)
//   in_valid   in   1       byte-stream valid
//   in_data    in   8       byte-stream data
//   in_ready   out  1       loader accepts byte this cycle
//   mem_we     out  1       instruction memory write strobe (one cycle per word)
//   mem_addr   out  ADDR_W  write address
//   mem_wdata  out  16      write data (assembled instruction)
//   pg         out  1       program mode to core (1 = core halted/being loaded)
//   core_rst   out  1       reset request to core, active-high
//   done       out  1       load completed, core running
//   err        out  1       sticky timeout error, cleared by start or rstz
// BEHAVIOUR
//   - Reset: state=IDLE, pg=1, core_rst=1, in_ready=0, mem_we=0, mem_addr=BASE_ADDR,
//     mem_wdata=0, done=0, err=0, word count=0, timeout counter=0.
//   - Byte transfer occurs on cycle with in_valid & in_ready; in_data ignored otherwise.
//   - Frame: LEN_HI, LEN_LO (N words, 16-bit, big-endian), then N x {HI byte, LO byte}.
//   - States / transitions:
//     IDLE:    pg=1, core_rst=1. start -> LEN_HI (err<=0, mem_addr<=BASE_ADDR).
//     LEN_HI:  in_ready=1; on xfer latch N[15:8] -> LEN_LO.
//     LEN_LO:  in_ready=1; on xfer latch N[7:0]; N==0 -> CORE_RST else -> DATA_HI.
//     DATA_HI: in_ready=1; on xfer latch wdata[15:8] -> DATA_LO.
//     DATA_LO: in_ready=1; on xfer latch wdata[7:0] -> WRITE.
//     WRITE:   in_ready=0, mem_we=1 for exactly one cycle at current mem_addr. Next cycle
//              mem_addr+1 and count+1. If count+1==N -> CORE_RST, else -> DATA_HI.
//     CORE_RST: pg=1, core_rst=1 for RST_CYCLES cycles -> RUN.
//     RUN:     pg=0, core_rst=0, done=1. start -> LEN_HI (pg=1, core_rst=1 next cycle, done=0).
//   - core_rst is 1 in every state except RUN; pg is 1 in every state except RUN.
//   - Latency: last LO byte xfer at cycle t -> mem_we at t+1. pg falls at
//     t+2+RST_CYCLES. A word needs min 3 cycles (HI, LO, WRITE).
//   - Timeout: counter clears on every xfer and on entry to LEN_HI. It increments each
//     cycle in LEN_LO/DATA_HI/DATA_LO while no xfer. Reaching TIMEOUT -> err=1, IDLE.
//     LEN_HI waits forever (no timeout before first byte).
//   - Address: mem_addr wraps modulo 2^ADDR_W. N up to 65535 legal; no overflow check.
//   - start is ignored in LEN_*/DATA_*/WRITE/CORE_RST (no abort mid-load except rstz/timeout).
//   - rstz mid-load: immediate return to reset values; already written words are not undone.
//   - mem_wdata holds last assembled word; it is valid whenever mem_we=1.
// STRUCTURE
//   - Shared header mas_defs.vh: state encodings (IDLE..RUN, 3 bits), frame byte-order note,
//     PG_RUN/PG_PROG constants also used by the core top level.
//   - One sub-module: mas_idle_timer (counter with clear/enable, TIMEOUT param, expiry pulse).
//   - FSM + word assembler + address/count registers remain in mas_prog_loader.
// TESTING
//   1 Reset: hold rstz 2 cycles -> pg=1, core_rst=1, done=0, err=0, in_ready=0, mem_we=0.
//   2 Load 3 words: start, bytes 00 03 00 01 05 02 0A 03 -> writes 0001@0, 0502@1, 0A03@2.
//     Each write is a single mem_we cycle; then core_rst for 2 cycles, then pg=0, done=1.
//   3 Backpressure/gaps: same frame with 5 idle cycles between bytes -> identical writes, no err.
//   4 Timeout (TIMEOUT=16): start, 00 02 00, stall 16 cycles -> err=1, IDLE, pg=1,
//     exactly 0 writes. Next start clears err.
//   5 N=0: start, 00 00 -> no mem_we, core_rst 2 cycles, then RUN. start in RUN re-enters
//     LEN_HI with pg=1.
//   6 Reset mid-load after 1 word written -> reset values next cycle. Reload
//     from BASE_ADDR succeeds.

Source files
------------

// File: rtl/mas_prog_loader_pkg.sv
// Shared definitions for the MAS16bA program loader: FSM encodings and core mode constants.
// Frame byte order is big-endian: LEN_HI, LEN_LO, then {HI, LO} per instruction word.
package mas_prog_loader_pkg;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_LEN_HI   = 3'd1,
      S_LEN_LO   = 3'd2,
      S_DATA_HI  = 3'd3,
      S_DATA_LO  = 3'd4,
      S_WRITE    = 3'd5,
      S_CORE_RST = 3'd6,
      S_RUN      = 3'd7
   } state_t;

   localparam logic PG_RUN  = 1'b0;
   localparam logic PG_PROG = 1'b1;

   function automatic logic accepts_byte(input state_t s);
      return (s == S_LEN_HI) || (s == S_LEN_LO) || (s == S_DATA_HI) || (s == S_DATA_LO);
   endfunction

   // Only the mid-frame states count idle cycles; LEN_HI may wait indefinitely for the first byte.
   function automatic logic is_timed(input state_t s);
      return (s == S_LEN_LO) || (s == S_DATA_HI) || (s == S_DATA_LO);
   endfunction

endpackage

// File: rtl/mas_idle_timer.sv
// Idle-cycle counter with clear/enable; pulses expire on the cycle the count would reach TIMEOUT.
module mas_idle_timer
   import mas_prog_loader_pkg::*;
#(
   parameter int TIMEOUT = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt;

   assign expire = en && !clr && (cnt == CW'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst || clr || expire) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/mas_prog_loader.sv
// Boot sequencer: assembles big-endian 16-bit words from a byte stream, writes them to
// instruction memory, then pulses core reset and releases the core into run mode.
module mas_prog_loader
   import mas_prog_loader_pkg::*;
#(
   parameter int          ADDR_W     = 16,
   parameter int unsigned BASE_ADDR  = 0,
   parameter int          TIMEOUT    = 1024,
   parameter int          RST_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rstz,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   output logic              pg,
   output logic              core_rst,
   output logic              done,
   output logic              err
);

   localparam int RCNT_W = $clog2(RST_CYCLES + 1);

   state_t            state, state_nxt;
   logic [15:0]       len;
   logic [15:0]       count;
   logic [RCNT_W-1:0] rst_cnt;
   logic              xfer;
   logic              start_load;
   logic              timer_clr;
   logic              timer_en;
   logic              expire;
   logic              last_word;

   assign in_ready  = accepts_byte(state);
   assign xfer      = in_valid && in_ready;
   assign mem_we    = (state == S_WRITE);
   assign pg        = (state == S_RUN) ? PG_RUN : PG_PROG;
   assign core_rst  = (state != S_RUN);
   assign done      = (state == S_RUN);
   assign last_word = (16'(count + 16'd1) == len);

   assign timer_en  = is_timed(state) && !xfer;
   assign timer_clr = xfer || start_load;

   mas_idle_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_idle_timer (
      .clk    (clk),
      .rst    (rstz),
      .clr    (timer_clr),
      .en     (timer_en),
      .expire (expire)
   );

   always_ff @(posedge clk) begin
      if (rstz) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      start_load = 1'b0;
      case (state)
         S_IDLE, S_RUN: begin
            if (start) begin
               state_nxt  = S_LEN_HI;
               start_load = 1'b1;
            end
         end
         S_LEN_HI: begin
            if (xfer) state_nxt = S_LEN_LO;
         end
         S_LEN_LO: begin
            // Length compare uses the byte arriving now, not the not-yet-updated register.
            if (xfer) state_nxt = ({len[15:8], in_data} == 16'd0) ? S_CORE_RST : S_DATA_HI;
         end
         S_DATA_HI: begin
            if (xfer) state_nxt = S_DATA_LO;
         end
         S_DATA_LO: begin
            if (xfer) state_nxt = S_WRITE;
         end
         S_WRITE: begin
            state_nxt = last_word ? S_CORE_RST : S_DATA_HI;
         end
         S_CORE_RST: begin
            if (rst_cnt == RCNT_W'(RST_CYCLES - 1)) state_nxt = S_RUN;
         end
         default: state_nxt = S_IDLE;
      endcase
      if (expire) state_nxt = S_IDLE;
   end

   always_ff @(posedge clk) begin
      if (rstz) begin
         len       <= '0;
         count     <= '0;
         mem_addr  <= ADDR_W'(BASE_ADDR);
         mem_wdata <= '0;
         err       <= 1'b0;
         rst_cnt   <= '0;
      end else begin
         if (start_load) begin
            err      <= 1'b0;
            mem_addr <= ADDR_W'(BASE_ADDR);
            count    <= '0;
         end else if (expire) begin
            err <= 1'b1;
         end

         if (xfer) begin
            case (state)
               S_LEN_HI:  len[15:8]       <= in_data;
               S_LEN_LO:  len[7:0]        <= in_data;
               S_DATA_HI: mem_wdata[15:8] <= in_data;
               S_DATA_LO: mem_wdata[7:0]  <= in_data;
               default: ;
            endcase
         end

         // Address wraps naturally at 2^ADDR_W; no length/overflow check by design.
         if (state == S_WRITE) begin
            mem_addr <= mem_addr + ADDR_W'(1);
            count    <= count + 16'd1;
         end

         if (state == S_CORE_RST) begin
            rst_cnt <= rst_cnt + RCNT_W'(1);
         end else begin
            rst_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_mas_prog_loader.sv
// Directed bench for mas_prog_loader: reset, frame loads, gaps, timeout, empty frame, mid-load reset.
module tb_mas_prog_loader;

   logic        clk = 1'b0;
   logic        rstz;
   logic        start;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        pg;
   logic        core_rst;
   logic        done;
   logic        err;

   int vectors     = 0;
   int miscompares = 0;

   logic [15:0] wr_addr[$];
   logic [15:0] wr_data[$];

   logic [7:0] frame3 [8];

   mas_prog_loader #(
      .ADDR_W     (16),
      .BASE_ADDR  (0),
      .TIMEOUT    (16),
      .RST_CYCLES (2)
   ) dut (
      .clk       (clk),
      .rstz      (rstz),
      .start     (start),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .pg        (pg),
      .core_rst  (core_rst),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (mem_we) begin
         wr_addr.push_back(mem_addr);
         wr_data.push_back(mem_wdata);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rstz = 1'b1;
      step();
      step();
      rstz = 1'b0;
      wr_addr.delete();
      wr_data.delete();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int budget;
      budget   = 0;
      in_valid = 1'b1;
      in_data  = b;
      while (!in_ready && budget < 200) begin
         step();
         budget++;
      end
      if (!in_ready) begin
         miscompares++;
         $display("FAIL send_byte_timeout in_ready got %b want 1", in_ready);
         vectors++;
      end
      step();
      in_valid = 1'b0;
      in_data  = 8'h00;
   endtask

   task automatic wait_done(input string tag);
      int budget;
      budget = 0;
      while (!done && budget < 50) begin
         step();
         budget++;
      end
      vectors++;
      if (done !== 1'b1) begin
         miscompares++;
         $display("FAIL %s_wait_done done got %b want 1", tag, done);
      end
   endtask

   // Flags are packed as {pg, core_rst, done, err, in_ready, mem_we}.
   task automatic test_reset();
      in_valid = 1'b0;
      in_data  = 8'h00;
      start    = 1'b0;
      rstz     = 1'b1;
      step();
      step();
      vectors++;
      if ({pg, core_rst, done, err, in_ready, mem_we} !== 6'b110000) begin
         miscompares++;
         $display("FAIL reset_flags got %b want %b", {pg, core_rst, done, err, in_ready, mem_we}, 6'b110000);
      end
      vectors++;
      if ({mem_addr, mem_wdata} !== 32'h0000_0000) begin
         miscompares++;
         $display("FAIL reset_addr_data got %h want %h", {mem_addr, mem_wdata}, 32'h0);
      end
      rstz = 1'b0;
      step();
      vectors++;
      if ({pg, core_rst, done, in_ready} !== 4'b1100) begin
         miscompares++;
         $display("FAIL reset_idle got %b want %b", {pg, core_rst, done, in_ready}, 4'b1100);
      end
   endtask

   task automatic test_load3();
      do_reset();
      pulse_start();
      for (int i = 0; i < 8; i++) send_byte(frame3[i]);
      vectors++;
      if ({mem_we, in_ready, mem_addr, mem_wdata} !== {2'b10, 16'h0002, 16'h0A03}) begin
         miscompares++;
         $display("FAIL load3_last_write got %b %b %h %h want 1 0 0002 0A03", mem_we, in_ready, mem_addr, mem_wdata);
      end
      step();
      vectors++;
      if ({pg, core_rst, done, mem_we, mem_addr} !== {4'b1100, 16'h0003}) begin
         miscompares++;
         $display("FAIL load3_rst1 got %b %b %b %b %h want 1 1 0 0 0003", pg, core_rst, done, mem_we, mem_addr);
      end
      step();
      vectors++;
      if ({pg, core_rst, done} !== 3'b110) begin
         miscompares++;
         $display("FAIL load3_rst2 got %b want %b", {pg, core_rst, done}, 3'b110);
      end
      step();
      vectors++;
      if ({pg, core_rst, done, err} !== 4'b0010) begin
         miscompares++;
         $display("FAIL load3_run got %b want %b", {pg, core_rst, done, err}, 4'b0010);
      end
      vectors++;
      if (wr_addr.size() !== 3) begin
         miscompares++;
         $display("FAIL load3_write_count got %0d want 3", wr_addr.size());
      end else begin
         vectors++;
         if ({wr_addr[0], wr_data[0], wr_addr[1], wr_data[1], wr_addr[2], wr_data[2]} !==
             {16'h0000, 16'h0001, 16'h0001, 16'h0502, 16'h0002, 16'h0A03}) begin
            miscompares++;
            $display("FAIL load3_writes got %h:%h %h:%h %h:%h want 0000:0001 0001:0502 0002:0A03",
                     wr_addr[0], wr_data[0], wr_addr[1], wr_data[1], wr_addr[2], wr_data[2]);
         end
      end
   endtask

   task automatic test_gaps();
      do_reset();
      pulse_start();
      for (int i = 0; i < 8; i++) begin
         send_byte(frame3[i]);
         if (i < 7) begin
            // start is raised mid-load here and must be ignored.
            if (i == 4) start = 1'b1;
            repeat (5) step();
            start = 1'b0;
         end
      end
      wait_done("gaps");
      vectors++;
      if ({err, pg, wr_addr.size()} !== {2'b00, 32'd3}) begin
         miscompares++;
         $display("FAIL gaps_status got err=%b pg=%b writes=%0d want err=0 pg=0 writes=3", err, pg, wr_addr.size());
      end else begin
         vectors++;
         if ({wr_addr[0], wr_data[0], wr_addr[1], wr_data[1], wr_addr[2], wr_data[2]} !==
             {16'h0000, 16'h0001, 16'h0001, 16'h0502, 16'h0002, 16'h0A03}) begin
            miscompares++;
            $display("FAIL gaps_writes got %h:%h %h:%h %h:%h want 0000:0001 0001:0502 0002:0A03",
                     wr_addr[0], wr_data[0], wr_addr[1], wr_data[1], wr_addr[2], wr_data[2]);
         end
      end
   endtask

   task automatic test_timeout();
      do_reset();
      pulse_start();
      send_byte(8'h00);
      send_byte(8'h02);
      send_byte(8'h00);
      repeat (15) step();
      vectors++;
      if ({err, in_ready} !== 2'b01) begin
         miscompares++;
         $display("FAIL timeout_before got err=%b in_ready=%b want err=0 in_ready=1", err, in_ready);
      end
      step();
      vectors++;
      if ({pg, core_rst, done, err, in_ready, mem_we} !== 6'b110100) begin
         miscompares++;
         $display("FAIL timeout_expired got %b want %b", {pg, core_rst, done, err, in_ready, mem_we}, 6'b110100);
      end
      repeat (3) step();
      vectors++;
      if ({err, wr_addr.size()} !== {1'b1, 32'd0}) begin
         miscompares++;
         $display("FAIL timeout_sticky got err=%b writes=%0d want err=1 writes=0", err, wr_addr.size());
      end
      pulse_start();
      vectors++;
      if ({err, in_ready, pg} !== 3'b011) begin
         miscompares++;
         $display("FAIL timeout_restart got %b want %b", {err, in_ready, pg}, 3'b011);
      end
   endtask

   task automatic test_zero_len();
      do_reset();
      pulse_start();
      send_byte(8'h00);
      send_byte(8'h00);
      vectors++;
      if ({pg, core_rst, done, in_ready, mem_we} !== 5'b11000) begin
         miscompares++;
         $display("FAIL zero_rst1 got %b want %b", {pg, core_rst, done, in_ready, mem_we}, 5'b11000);
      end
      step();
      vectors++;
      if ({pg, core_rst, done} !== 3'b110) begin
         miscompares++;
         $display("FAIL zero_rst2 got %b want %b", {pg, core_rst, done}, 3'b110);
      end
      step();
      vectors++;
      if ({pg, core_rst, done, wr_addr.size(), mem_addr} !== {3'b001, 32'd0, 16'h0000}) begin
         miscompares++;
         $display("FAIL zero_run got pg=%b rst=%b done=%b writes=%0d addr=%h want 0 0 1 0 0000",
                  pg, core_rst, done, wr_addr.size(), mem_addr);
      end
      pulse_start();
      vectors++;
      if ({pg, core_rst, done, in_ready} !== 4'b1101) begin
         miscompares++;
         $display("FAIL zero_restart got %b want %b", {pg, core_rst, done, in_ready}, 4'b1101);
      end
   endtask

   task automatic test_reset_midload();
      do_reset();
      pulse_start();
      for (int i = 0; i < 4; i++) send_byte(frame3[i]);
      step();
      in_valid = 1'b1;
      in_data  = 8'h05;
      rstz     = 1'b1;
      step();
      rstz     = 1'b0;
      in_valid = 1'b0;
      vectors++;
      if ({pg, core_rst, done, err, in_ready, mem_we, mem_addr, mem_wdata} !== {6'b110000, 32'h0}) begin
         miscompares++;
         $display("FAIL midrst_values got %b %h %h want 110000 0000 0000",
                  {pg, core_rst, done, err, in_ready, mem_we}, mem_addr, mem_wdata);
      end
      vectors++;
      if (wr_addr.size() !== 1) begin
         miscompares++;
         $display("FAIL midrst_partial got %0d writes want 1", wr_addr.size());
      end
      wr_addr.delete();
      wr_data.delete();
      pulse_start();
      for (int i = 0; i < 8; i++) send_byte(frame3[i]);
      wait_done("midrst");
      vectors++;
      if (wr_addr.size() !== 3) begin
         miscompares++;
         $display("FAIL midrst_reload_count got %0d want 3", wr_addr.size());
      end else begin
         vectors++;
         if ({wr_addr[0], wr_data[0], wr_addr[2], wr_data[2]} !== {16'h0000, 16'h0001, 16'h0002, 16'h0A03}) begin
            miscompares++;
            $display("FAIL midrst_reload got %h:%h %h:%h want 0000:0001 0002:0A03",
                     wr_addr[0], wr_data[0], wr_addr[2], wr_data[2]);
         end
      end
   endtask

   initial begin
      frame3[0] = 8'h00; frame3[1] = 8'h03;
      frame3[2] = 8'h00; frame3[3] = 8'h01;
      frame3[4] = 8'h05; frame3[5] = 8'h02;
      frame3[6] = 8'h0A; frame3[7] = 8'h03;
      test_reset();
      test_load3();
      test_gaps();
      test_timeout();
      test_zero_len();
      test_reset_midload();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
